// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared constants, state encodings and a counter-width helper for the UART echo block.
package uart_pkg;

  localparam int DATA_W                = 8;
  localparam int BAUD_CNT_END_DEF      = 5207;
  localparam int BAUD_CNT_END_HALF_DEF = 2603;
  localparam int FIFO_DEPTH_DEF        = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_BUSY
  } rx_state_e;

  function automatic int cnt_w(input int end_val);
    return (end_val < 1) ? 1 : $clog2(end_val + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// First-word-fall-through byte FIFO; a push into a full FIFO is dropped, a pop
// from an empty FIFO is ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 receiver: synchronises the pin, starts on a falling edge, samples every bit
// at mid-point and emits a one-clock valid pulse for frames with a good stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_END      = BAUD_CNT_END_DEF,
  parameter int BAUD_CNT_END_HALF = BAUD_CNT_END_HALF_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  localparam int CW = cnt_w(BAUD_CNT_END);

  logic              rx_meta_q, rx_sync_q, rx_dly_q;
  logic              fall;
  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  assign fall    = rx_dly_q & ~rx_sync_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  // bit_q: 0 = start bit, 1..8 = data bits LSB first, 9 = stop bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_BUSY;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      RX_BUSY: begin
        if (cnt_q == CW'(BAUD_CNT_END)) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_q == CW'(BAUD_CNT_END_HALF)) begin
          if (bit_q == 4'd0) begin
            if (rx_sync_q) begin
              state_d = RX_IDLE;
              cnt_d   = '0;
              bit_d   = '0;
            end
          end else if (bit_q == 4'd9) begin
            valid_d = rx_sync_q;
            state_d = RX_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            data_d = {rx_sync_q, data_q[DATA_W-1:1]};
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchroniser flops reset high so the idle line never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_dly_q  <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_dly_q  <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// 8N1 transmitter: pops a byte from the FIFO whenever idle (or at the end of a
// stop bit) and shifts it out LSB first with a registered output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CNT_BAUD_END = BAUD_CNT_END_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_pop_o,
  output logic              tx_o
);

  localparam int CW = cnt_w(CNT_BAUD_END);

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              last;

  assign last = (cnt_q == CW'(CNT_BAUD_END));
  assign tx_o = tx_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = last ? '0 : cnt_q + CW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop_o = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty_i) begin
          fifo_pop_o = 1'b1;
          shift_d    = fifo_data_i;
          state_d    = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (last) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (last) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        // Chain straight into the next frame so a steady stream never slips a clock.
        if (last) begin
          if (!fifo_empty_i) begin
            fifo_pop_o = 1'b1;
            shift_d    = fifo_data_i;
            state_d    = TX_START;
            tx_d       = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/uart_top.sv
`timescale 1ns/1ps
// UART echo: receiver -> byte FIFO -> transmitter, all on the single sclk domain.
module uart_top
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_END      = BAUD_CNT_END_DEF,
  parameter int BAUD_CNT_END_HALF = BAUD_CNT_END_HALF_DEF,
  parameter int CNT_BAUD_END      = BAUD_CNT_END_DEF,
  parameter int FIFO_DEPTH        = FIFO_DEPTH_DEF
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic rx,
  output logic tx
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_pop;

  uart_rx #(
    .BAUD_CNT_END      (BAUD_CNT_END),
    .BAUD_CNT_END_HALF (BAUD_CNT_END_HALF)
  ) rx_inst (
    .clk_i   (sclk),
    .rst_ni  (rst_n),
    .rx_i    (rx),
    .data_o  (rx_data),
    .valid_o (rx_valid)
  );

  sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) fifo_inst (
    .clk_i   (sclk),
    .rst_ni  (rst_n),
    .push_i  (rx_valid),
    .data_i  (rx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty)
  );

  uart_tx #(
    .CNT_BAUD_END (CNT_BAUD_END)
  ) tx_inst (
    .clk_i        (sclk),
    .rst_ni       (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_pop_o   (fifo_pop),
    .tx_o         (tx)
  );

endmodule

// File: tb/tb_uart_top.sv
`timescale 1ns/1ps
// Directed bench for the UART echo block at a shortened 16-clock bit period.
module tb_uart_top;

  localparam int P      = 16;
  localparam int CLK_NS = 20;

  logic sclk  = 1'b0;
  logic rst_n = 1'b1;
  logic rx    = 1'b1;
  logic tx;

  logic       f_push = 1'b0;
  logic       f_pop  = 1'b0;
  logic [7:0] f_din  = 8'h00;
  logic [7:0] f_dout;
  logic       f_empty;

  always #10 sclk = ~sclk;

  uart_top #(
    .BAUD_CNT_END      (P - 1),
    .BAUD_CNT_END_HALF (P/2 - 1),
    .CNT_BAUD_END      (P - 1),
    .FIFO_DEPTH        (16)
  ) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .rx    (rx),
    .tx    (tx)
  );

  sync_fifo #(.DEPTH(4), .DATA_W(8)) u_fifo (
    .clk_i   (sclk),
    .rst_ni  (rst_n),
    .push_i  (f_push),
    .data_i  (f_din),
    .pop_i   (f_pop),
    .data_o  (f_dout),
    .empty_o (f_empty)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // tx edge log
  int  tx_edges = 0;
  time ed_t [256];
  always @(tx) begin
    ed_t[tx_edges % 256] = $time;
    tx_edges = tx_edges + 1;
  end

  // tx frame decoder, sampling at bit mid-points on the falling clock edge
  int got_b [256];
  int got_n    = 0;
  int got_ferr = 0;
  initial begin : mon
    logic [7:0] b;
    logic       sb;
    b  = 8'h00;
    sb = 1'b0;
    forever begin
      @(negedge sclk);
      if (rst_n && tx === 1'b0) begin
        repeat (P/2) @(negedge sclk);
        for (int i = 0; i < 8; i++) begin
          repeat (P) @(negedge sclk);
          b[i] = tx;
        end
        repeat (P) @(negedge sclk);
        sb = tx;
        if (sb === 1'b1) begin
          got_b[got_n % 256] = int'(b);
          got_n = got_n + 1;
        end else begin
          got_ferr = got_ferr + 1;
        end
      end
    end
  end

  time stop_t = 0;

  // Caller is aligned 1 ns after a rising edge; returns with the same alignment.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == 9) stop_t = $time;
      repeat (P) @(posedge sclk);
      #1;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  int stream_v [24] = '{'h00, 'hFF, 'h55, 'hAA, 'h01, 'h80, 'h7F, 'hFE,
                        'h3C, 'hC3, 'h0F, 'hF0, 'h12, 'h34, 'h56, 'h78,
                        'h9A, 'hBC, 'hDE, 'hF1, 'h00, 'hFF, 'h81, 'h18};

  initial begin : main
    int base, gbase, fer, d, lat;
    #1 rst_n = 1'b0;
    #1 chk("rst_tx_async", int'(tx), 1);
    #29 rst_n = 1'b1;

    // idle after reset
    base = tx_edges;
    wait_clks(10*P);
    chk("rst_tx_idle", int'(tx), 1);
    chk("rst_no_edges", tx_edges - base, 0);

    // FIFO: overflow drop, order, push+pop in one clock
    for (int i = 0; i < 5; i++) begin
      f_push = 1'b1;
      f_din  = 8'(16 + i);
      wait_clks(1);
    end
    f_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ff_order", int'(f_dout), 16 + i);
      f_pop = 1'b1;
      wait_clks(1);
      f_pop = 1'b0;
    end
    chk("ff_drop_when_full", int'(f_empty), 1);
    f_push = 1'b1;
    f_din  = 8'hA0;
    wait_clks(1);
    f_din = 8'hA1;
    f_pop = 1'b1;
    wait_clks(1);
    f_push = 1'b0;
    f_pop  = 1'b0;
    chk("ff_pushpop_data", int'(f_dout), 'hA1);
    chk("ff_pushpop_nonempty", int'(f_empty), 0);
    f_pop = 1'b1;
    wait_clks(1);
    f_pop = 1'b0;
    chk("ff_pushpop_drained", int'(f_empty), 1);

    // single byte 0x55: every bit toggles, so edges are exactly one bit apart
    base  = tx_edges;
    gbase = got_n;
    send_byte(8'h55, 1'b1);
    wait_clks(12*P);
    chk("b55_count", got_n - gbase, 1);
    chk("b55_data", got_b[gbase % 256], 'h55);
    chk("b55_edges", tx_edges - base, 10);
    chk("b55_start_level", int'(ed_t[base % 256] > 0), 1);
    for (int i = 1; i < 10; i++) begin
      d = int'((ed_t[(base + i) % 256] - ed_t[(base + i - 1) % 256]) / CLK_NS);
      chk("b55_bit_period", d, P);
    end
    lat = int'((ed_t[base % 256] - stop_t + CLK_NS/2) / CLK_NS);
    chk("b55_echo_latency", int'(lat >= P/2 && lat <= P/2 + 6), 1);

    // back-to-back stream
    gbase = got_n;
    fer   = got_ferr;
    for (int i = 0; i < 24; i++) send_byte(stream_v[i][7:0], 1'b1);
    wait_clks(12*P);
    chk("stream_count", got_n - gbase, 24);
    for (int i = 0; i < 24; i++) chk("stream_data", got_b[(gbase + i) % 256], stream_v[i]);
    chk("stream_tx_framing", got_ferr - fer, 0);

    // framing error then a good byte
    gbase = got_n;
    send_byte(8'hA3, 1'b0);
    rx = 1'b1;
    wait_clks(2*P);
    send_byte(8'h3C, 1'b1);
    wait_clks(12*P);
    chk("ferr_count", got_n - gbase, 1);
    chk("ferr_next_data", got_b[gbase % 256], 'h3C);

    // short low glitch on idle line
    base  = tx_edges;
    gbase = got_n;
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(12*P);
    chk("glitch_tx_idle", int'(tx), 1);
    chk("glitch_no_edges", tx_edges - base, 0);
    chk("glitch_no_byte", got_n - gbase, 0);

    // reset while 0x81 is in its data bits (bit 2 is low)
    send_byte(8'h81, 1'b1);
    wait_clks(3*P);
    chk("midrst_pre_tx_low", int'(tx), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_high", int'(tx), 1);
    repeat (3) @(posedge sclk);
    #1 rst_n = 1'b1;
    base = tx_edges;
    wait_clks(12*P);
    chk("midrst_quiet", tx_edges - base, 0);
    gbase = got_n;
    send_byte(8'h7E, 1'b1);
    wait_clks(12*P);
    chk("midrst_next_count", got_n - gbase, 1);
    chk("midrst_next_data", got_b[gbase % 256], 'h7E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
